// File: rtl/x2821_pkg.sv
// Shared defaults and qualifier state encoding for the input-conditioning blocks.
package x2821_pkg;

    localparam int DEBOUNCE_STABLE_DEF = 16;
    localparam int SYNC_STAGES_DEF     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        QUAL = 1'b1
    } dbs_state_t;

endpackage

// File: rtl/sync_ff.sv
// N-flop level synchronizer with asynchronous active-low reset to RST_VAL.
module sync_ff #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] chain_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= {N{RST_VAL}};
        end else begin
            chain_q <= {chain_q[N-2:0], d_i};
        end
    end

    assign q_o = chain_q[N-1];

endmodule

// File: rtl/sw_debounce.sv
// Switch/line debouncer: synchronizer, tick-qualified stability counter, edge strobes.
// Optional bounce counter enabled with `define SWDB_BOUNCE_CNT_EN.
module sw_debounce
    import x2821_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int   STABLE      = DEBOUNCE_STABLE_DEF,
    parameter logic INIT        = 1'b0,
    parameter int   BCNT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_raw,
    input  logic              i_tick,
`ifdef SWDB_BOUNCE_CNT_EN
    input  logic              i_bounce_clr,
    output logic [BCNT_W-1:0] o_bounces,
`endif
    output logic              o_level,
    output logic              o_rise,
    output logic              o_fall
);

    localparam int             CW   = $clog2(STABLE + 1);
    localparam logic [CW-1:0]  LAST = CW'(STABLE - 1);

    generate
        if (SYNC_STAGES < 2 || STABLE < 1 || BCNT_W < 1) begin : g_bad_param
            $error("sw_debounce: illegal parameters (SYNC_STAGES >= 2, STABLE >= 1 required)");
        end
    endgenerate

    logic          s;
    logic          differ;
    dbs_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    sync_ff #(
        .N       (SYNC_STAGES),
        .RST_VAL (INIT)
    ) u_sync (
        .clk_i  (i_clk),
        .rst_ni (i_reset_n),
        .d_i    (i_raw),
        .q_o    (s)
    );

    assign differ = (s != level_q);

    // A QUAL abort happens on any edge where the synchronized input falls back to the held level.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= INIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (differ) begin
                        if (STABLE == 1 && i_tick) begin
                            level_q <= s;
                            rise_q  <= s;
                            fall_q  <= ~s;
                        end else begin
                            state_q <= QUAL;
                            cnt_q   <= i_tick ? CW'(1) : '0;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                QUAL: begin
                    if (!differ) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (i_tick) begin
                        if (cnt_q == LAST) begin
                            level_q <= s;
                            rise_q  <= s;
                            fall_q  <= ~s;
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef SWDB_BOUNCE_CNT_EN
    logic              abort;
    logic [BCNT_W-1:0] bcnt_q;

    assign abort = (state_q == QUAL) && !differ;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bcnt_q <= '0;
        end else if (i_bounce_clr) begin
            bcnt_q <= '0;
        end else if (abort && (bcnt_q != {BCNT_W{1'b1}})) begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
        end
    end

    assign o_bounces = bcnt_q;
`endif

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce: default, STABLE=1/SYNC_STAGES=3 and INIT=1 instances.
module tb_sw_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic tick;
    logic raw0, raw1, raw2;
    logic lvl0, rise0, fall0;
    logic lvl1, rise1, fall1;
    logic lvl2, rise2, fall2;
`ifdef SWDB_BOUNCE_CNT_EN
    logic       clr;
    logic [7:0] bnc0, bnc1, bnc2;
`endif

    int nvec = 0;
    int nerr = 0;
    logic seen_strobe;

    always #5 clk = ~clk;

    sw_debounce #(.SYNC_STAGES(2), .STABLE(16), .INIT(1'b0), .BCNT_W(8)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_raw(raw0), .i_tick(tick),
`ifdef SWDB_BOUNCE_CNT_EN
        .i_bounce_clr(clr), .o_bounces(bnc0),
`endif
        .o_level(lvl0), .o_rise(rise0), .o_fall(fall0));

    sw_debounce #(.SYNC_STAGES(3), .STABLE(1), .INIT(1'b0), .BCNT_W(8)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_raw(raw1), .i_tick(tick),
`ifdef SWDB_BOUNCE_CNT_EN
        .i_bounce_clr(clr), .o_bounces(bnc1),
`endif
        .o_level(lvl1), .o_rise(rise1), .o_fall(fall1));

    sw_debounce #(.SYNC_STAGES(2), .STABLE(2), .INIT(1'b1), .BCNT_W(8)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_raw(raw2), .i_tick(tick),
`ifdef SWDB_BOUNCE_CNT_EN
        .i_bounce_clr(clr), .o_bounces(bnc2),
`endif
        .o_level(lvl2), .o_rise(rise2), .o_fall(fall2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b1;
        raw0 = 1'b0; raw1 = 1'b0; raw2 = 1'b1;
`ifdef SWDB_BOUNCE_CNT_EN
        clr = 1'b0;
`endif
        step(); step();
        chk("rst_level0", {31'd0, lvl0}, 32'd0);
        chk("rst_strobes0", {30'd0, rise0, fall0}, 32'd0);
        chk("rst_level2_init1", {31'd0, lvl2}, 32'd1);
        rst_n = 1'b1;

        // 10-cycle pulse from level 0 is rejected
        seen_strobe = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            raw0 = (k <= 10);
            step();
            seen_strobe = seen_strobe | rise0 | fall0;
        end
        chk("glitch_level", {31'd0, lvl0}, 32'd0);
        chk("glitch_nostrobe", {31'd0, seen_strobe}, 32'd0);
`ifdef SWDB_BOUNCE_CNT_EN
        chk("glitch_bounces", {24'd0, bnc0}, 32'd1);
`endif

        // rising edge accepted on edge 18
        raw0 = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            step();
            if (k == 17) chk("rise_e17_level", {31'd0, lvl0}, 32'd0);
            if (k == 18) begin
                chk("rise_e18_level", {31'd0, lvl0}, 32'd1);
                chk("rise_e18_strobes", {30'd0, rise0, fall0}, 32'd2);
            end
            if (k == 19) chk("rise_e19_strobes", {30'd0, rise0, fall0}, 32'd0);
        end
        step(); step();

        // 1-in-4 tick: first qualifying tick on edge 3, accept on edge 63
        raw0 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick = ((k % 4) == 3);
            step();
            if (k == 62) chk("tick_e62_level", {31'd0, lvl0}, 32'd1);
            if (k == 63) begin
                chk("tick_e63_level", {31'd0, lvl0}, 32'd0);
                chk("tick_e63_strobes", {30'd0, rise0, fall0}, 32'd1);
            end
            if (k == 64) chk("tick_e64_strobes", {30'd0, rise0, fall0}, 32'd0);
        end
        tick = 1'b1;
        step(); step();

        // one-cycle dropout aborts on edge 10, requalify from edge 11, accept on edge 26
        raw0 = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            if (k == 8) raw0 = 1'b0;
            if (k == 9) raw0 = 1'b1;
            step();
            if (k == 18) chk("restart_e18_level", {31'd0, lvl0}, 32'd0);
            if (k == 25) chk("restart_e25_level", {31'd0, lvl0}, 32'd0);
            if (k == 26) begin
                chk("restart_e26_level", {31'd0, lvl0}, 32'd1);
                chk("restart_e26_rise", {31'd0, rise0}, 32'd1);
            end
        end

        // async reset mid-QUAL while level is 1
        raw0 = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_qual_level", {31'd0, lvl0}, 32'd0);
        chk("arst_qual_strobes", {30'd0, rise0, fall0}, 32'd0);
        step();
        raw0 = 1'b1;
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 17) chk("post_rst_e17_level", {31'd0, lvl0}, 32'd0);
            if (k == 18) chk("post_rst_e18_rise", {30'd0, lvl0, rise0}, 32'd3);
        end
        // async reset while the rise strobe is high
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strobe_level", {31'd0, lvl0}, 32'd0);
        chk("arst_strobe_rise", {31'd0, rise0}, 32'd0);
        chk("arst_level2_init", {31'd0, lvl2}, 32'd1);
        step();
        raw0 = 1'b0;
        rst_n = 1'b1;
        step();

        // STABLE=1/SYNC=3 accepts on edge 4; INIT=1/STABLE=2 falls on edge 4
        raw1 = 1'b1; raw2 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) begin
                chk("s1_e3_level", {31'd0, lvl1}, 32'd0);
                chk("init1_e3_level", {31'd0, lvl2}, 32'd1);
            end
            if (k == 4) begin
                chk("s1_e4_level_strobes", {29'd0, lvl1, rise1, fall1}, 32'd6);
                chk("init1_e4_level_strobes", {29'd0, lvl2, rise2, fall2}, 32'd1);
            end
            if (k == 5) begin
                chk("s1_e5_strobes", {30'd0, rise1, fall1}, 32'd0);
                chk("init1_e5_strobes", {30'd0, rise2, fall2}, 32'd0);
            end
        end
        raw1 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) chk("s1_fall_e3_level", {31'd0, lvl1}, 32'd1);
            if (k == 4) chk("s1_fall_e4", {29'd0, lvl1, rise1, fall1}, 32'd1);
        end

`ifdef SWDB_BOUNCE_CNT_EN
        // 300 single-cycle glitches against level 0 saturate the counter
        for (int i = 0; i < 300; i++) begin
            raw0 = 1'b1; step();
            raw0 = 1'b0; step(); step(); step();
        end
        chk("bounce_sat", {24'd0, bnc0}, 32'd255);
        chk("bounce_level", {31'd0, lvl0}, 32'd0);
        raw0 = 1'b1; step();
        raw0 = 1'b0; step(); step();
        clr = 1'b1; step();
        clr = 1'b0;
        chk("bounce_clr_wins", {24'd0, bnc0}, 32'd0);
        raw0 = 1'b1; step();
        raw0 = 1'b0; step(); step(); step();
        chk("bounce_after_clr", {24'd0, bnc0}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
Conditions one raw asynchronous level input, such as a panel switch, console key or external line, for use inside the i_clk domain.
- Input passes through a multi-flop synchronizer.
- Level must stay stable for STABLE qualifying ticks before the clean output follows it.
- Also emits one-cycle rise/fall strobes.
- Sits directly upstream of the single-shot pulse stage; o_level drives that stage's i_in, with INIT matching its NE.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops (legal: >= 2).
STABLE, 16, consecutive qualifying ticks of disagreement needed to accept a new level (legal: >= 1).
INIT, 1'b0, reset value of synchronizer flops and o_level.
BCNT_W, 8, width of bounce counter (optional feature only).

Ports:
i_clk  input  1  clock; all logic on rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_raw  input  1  raw asynchronous level; not related to i_clk.
i_tick  input  1  qualification enable; tie to 1 for per-cycle counting.
o_level  output  1  debounced, synchronized level.
o_rise  output  1  one-cycle strobe when o_level goes 0->1.
o_fall  output  1  one-cycle strobe when o_level goes 1->0.

Behaviour:
- Reset (i_reset_n=0, asynchronous assert) sets:
  - sync flops = INIT, o_level = INIT.
  - o_rise = 0, o_fall = 0.
  - qualification counter cnt = 0, state = IDLE.
- Reset deassertion needs no special handling; first update is on the first edge with i_reset_n=1.
- Synchronizer: s = last flop of a SYNC_STAGES shift chain clocked from i_raw. No other logic samples i_raw.
- cnt width: clog2(STABLE+1) bits. Never exceeds STABLE-1. No wrap.
- State IDLE (s == o_level):
  - cnt held 0.
  - On an edge with s != o_level: go to QUAL. If i_tick=1, cnt <= 1; else cnt stays 0.
  - Special case STABLE=1 with i_tick=1: accept immediately (see accept rule), no QUAL.
- State QUAL:
  - Any edge with s == o_level: abort. cnt <= 0, back to IDLE, no output change. Applies regardless of i_tick.
  - Edge with s != o_level and i_tick=1:
    - if cnt == STABLE-1: accept.
    - else cnt <= cnt+1.
  - Edge with s != o_level and i_tick=0: hold cnt.
- Accept, on that edge:
  - o_level <= s.
  - o_rise <= s, o_fall <= ~s.
  - cnt <= 0, state IDLE.
- Strobes: high exactly one cycle after accept, otherwise 0. o_rise and o_fall are never both 1.
- Latency, with i_tick=1 and i_raw stable:
  - o_level changes on edge number SYNC_STAGES+STABLE, counting as edge 1 the first edge that samples the new i_raw.
  - Defaults: edge 18.
- Glitch rejection: any excursion of s shorter than STABLE ticks never reaches o_level.
- Reset mid-QUAL: all progress discarded; o_level returns to INIT even if it was accepted differently.
- Illegal parameters (SYNC_STAGES<2 or STABLE<1): elaboration-time error.

Optional Feature:
Macro: SWDB_BOUNCE_CNT_EN.
- Defined:
  - Adds port o_bounces (output, BCNT_W) and port i_bounce_clr (input, 1).
  - o_bounces increments on every QUAL abort, saturating at all-ones.
  - i_bounce_clr=1 zeroes it. If a clear and an abort land on the same edge, clear wins and the result is 0.
  - Reset value of o_bounces: 0.
- Undefined: both ports and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package x2821_pkg holds:
  - DEBOUNCE_STABLE_DEF = 16.
  - SYNC_STAGES_DEF = 2.
  - enum dbs_state_t {IDLE, QUAL}.
- One sub-module: sync_ff, a parameterized N-flop synchronizer with async active-low reset and a reset-value parameter. It is reused by other input paths.
- Qualifier FSM and strobes stay in sw_debounce.

Test Plan:
1. Reset with INIT=0, then i_raw 0->1 held, i_tick=1 -> o_level rises on edge 18 after first sample; o_rise=1 for exactly one cycle; o_fall stays 0.
2. i_raw 1-pulse lasting 10 cycles from level 0 -> o_level stays 0; no strobes. With the feature on, o_bounces = 1.
3. i_tick high 1 cycle in 4, raw 1->0 held -> o_level falls after 16 ticks (~64 cycles); o_fall single pulse. Dropping s back to 1 for one cycle mid-count restarts the count.
4. Assert i_reset_n=0 asynchronously mid-QUAL, then after o_level has already accepted 1 -> o_level, o_rise and o_fall go to INIT/0 immediately without a clock edge; cnt restarts from 0.
5. STABLE=1, SYNC_STAGES=3 -> o_level follows i_raw on edge 4 with a strobe. Parameter sweep with INIT=1 -> first accepted change is a fall.
6. Feature on: 300 aborted bounces with BCNT_W=8 -> o_bounces saturates at 255. i_bounce_clr on the same edge as an abort -> 0.
